dual_port_bram_arbiter: RTL and testbench

- Round-robin arbiter that shares one dual-port block RAM (two ports, 1-cycle registered read, read-enable-low returns zero) between p_NUM_REQ requesters.
- Grants up to two requests per cycle, one per BRAM port.
- Resolves same-address hazards by deferring a request, never by corrupting data.
- Sits between client engines and the RAM; drives the RAM control pins directly and routes read data back to the issuing requester.

---
 rtl/dual_port_bram_arbiter_if.sv | 34 +++
 rtl/dual_port_bram_arbiter.sv | 151 +++++++++++++++
 tb/tb_dual_port_bram_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_port_bram_arbiter_if.sv
// rtl/dual_port_bram_arbiter_if.sv - requester-side request/response bus of the dual-port BRAM arbiter
//
// Signals (requester k occupies bit k / slice k of every vector):
//   i_REQ_VALID    request valid
//   i_REQ_WRITE    1 = write, 0 = read
//   i_REQ_ADDRESS  request address
//   i_REQ_WDATA    write data
//   o_REQ_READY    grant; a request is accepted when valid & ready
//   o_RSP_VALID    one-cycle read response strobe
//   o_RSP_DATA     read data, zero in slices that are not valid
// Modports: master = client engines, slave = arbiter.
interface dual_port_bram_arbiter_if #(
    parameter int p_NUM_REQ       = 4,
    parameter int p_ADDRESS_WIDTH = 4,
    parameter int p_DATA_WIDTH    = 8
);
    logic [p_NUM_REQ-1:0]                 i_REQ_VALID;
    logic [p_NUM_REQ-1:0]                 i_REQ_WRITE;
    logic [p_NUM_REQ*p_ADDRESS_WIDTH-1:0] i_REQ_ADDRESS;
    logic [p_NUM_REQ*p_DATA_WIDTH-1:0]    i_REQ_WDATA;
    logic [p_NUM_REQ-1:0]                 o_REQ_READY;
    logic [p_NUM_REQ-1:0]                 o_RSP_VALID;
    logic [p_NUM_REQ*p_DATA_WIDTH-1:0]    o_RSP_DATA;

    modport master (
        output i_REQ_VALID, i_REQ_WRITE, i_REQ_ADDRESS, i_REQ_WDATA,
        input  o_REQ_READY, o_RSP_VALID, o_RSP_DATA
    );

    modport slave (
        input  i_REQ_VALID, i_REQ_WRITE, i_REQ_ADDRESS, i_REQ_WDATA,
        output o_REQ_READY, o_RSP_VALID, o_RSP_DATA
    );
endinterface

// File: rtl/dual_port_bram_arbiter.sv
// rtl/dual_port_bram_arbiter.sv - round-robin arbiter sharing one dual-port BRAM among p_NUM_REQ requesters
//
// Ports:
//   i_CLK, i_RESET_N        clock, asynchronous active-low reset
//   req_bus                 requester request/response bus (slave side)
//   o_WRITE_ENABLE_A/B      BRAM write enables
//   o_READ_ENABLE_A/B       BRAM read enables
//   o_WRITE_ADDRESS_A/B     BRAM write addresses
//   o_READ_ADDRESS_A/B      BRAM read addresses
//   o_WRITE_DATA_A/B        BRAM write data
//   i_READ_DATA_A/B         BRAM registered read data (one cycle after read enable)
module dual_port_bram_arbiter #(
    parameter int p_NUM_REQ       = 4,
    parameter int p_ADDRESS_WIDTH = 4,
    parameter int p_DATA_WIDTH    = 8
) (
    input  logic                       i_CLK,
    input  logic                       i_RESET_N,
    dual_port_bram_arbiter_if.slave    req_bus,
    output logic                       o_WRITE_ENABLE_A,
    output logic                       o_READ_ENABLE_A,
    output logic [p_ADDRESS_WIDTH-1:0] o_WRITE_ADDRESS_A,
    output logic [p_ADDRESS_WIDTH-1:0] o_READ_ADDRESS_A,
    output logic [p_DATA_WIDTH-1:0]    o_WRITE_DATA_A,
    input  logic [p_DATA_WIDTH-1:0]    i_READ_DATA_A,
    output logic                       o_WRITE_ENABLE_B,
    output logic                       o_READ_ENABLE_B,
    output logic [p_ADDRESS_WIDTH-1:0] o_WRITE_ADDRESS_B,
    output logic [p_ADDRESS_WIDTH-1:0] o_READ_ADDRESS_B,
    output logic [p_DATA_WIDTH-1:0]    o_WRITE_DATA_B,
    input  logic [p_DATA_WIDTH-1:0]    i_READ_DATA_B
);
    localparam int c_PTR_WIDTH = (p_NUM_REQ > 1) ? $clog2(p_NUM_REQ) : 1;

    logic [c_PTR_WIDTH-1:0] r_RR_PTR;
    logic [p_NUM_REQ-1:0]   r_RSP_PENDING;
    // 1 = the pending read was issued on port B, 0 = port A
    logic [p_NUM_REQ-1:0]   r_RSP_PORT;

    logic                   w1_found, w2_found;
    logic [c_PTR_WIDTH-1:0] w1_idx, w2_idx;
    logic [c_PTR_WIDTH-1:0] last_idx, ptr_next;
    logic [p_NUM_REQ-1:0]   grant, port_b_sel;

    // Round-robin scan from r_RR_PTR. Winner 1 takes port A; winner 2 is the
    // next valid requester that does not hit winner 1's address with a write
    // involved. Conflicting candidates are simply passed over this cycle.
    always_comb begin
        int                       idx;
        logic [p_ADDRESS_WIDTH-1:0] w1_addr;
        logic                     w1_write;
        idx      = 0;
        w1_addr  = '0;
        w1_write = 1'b0;
        w1_found = 1'b0;
        w2_found = 1'b0;
        w1_idx   = '0;
        w2_idx   = '0;
        for (int off = 0; off < p_NUM_REQ; off++) begin
            idx = int'(r_RR_PTR) + off;
            if (idx >= p_NUM_REQ) idx = idx - p_NUM_REQ;
            if (i_RESET_N && req_bus.i_REQ_VALID[idx]) begin
                if (!w1_found) begin
                    w1_found = 1'b1;
                    w1_idx   = c_PTR_WIDTH'(idx);
                    w1_addr  = req_bus.i_REQ_ADDRESS[idx*p_ADDRESS_WIDTH +: p_ADDRESS_WIDTH];
                    w1_write = req_bus.i_REQ_WRITE[idx];
                end else if (!w2_found &&
                             !((w1_addr == req_bus.i_REQ_ADDRESS[idx*p_ADDRESS_WIDTH +: p_ADDRESS_WIDTH]) &&
                               (w1_write || req_bus.i_REQ_WRITE[idx]))) begin
                    w2_found = 1'b1;
                    w2_idx   = c_PTR_WIDTH'(idx);
                end
            end
        end
    end

    always_comb begin
        grant      = '0;
        port_b_sel = '0;
        if (w1_found) grant[w1_idx] = 1'b1;
        if (w2_found) begin
            grant[w2_idx]      = 1'b1;
            port_b_sel[w2_idx] = 1'b1;
        end
    end

    // Winner 2 always lies later in scan order than winner 1, so it is the
    // last granted index whenever it exists.
    assign last_idx = w2_found ? w2_idx : w1_idx;
    assign ptr_next = (int'(last_idx) == p_NUM_REQ - 1) ? '0 : last_idx + 1'b1;

    always_comb begin
        o_WRITE_ENABLE_A  = 1'b0;
        o_READ_ENABLE_A   = 1'b0;
        o_WRITE_ADDRESS_A = '0;
        o_READ_ADDRESS_A  = '0;
        o_WRITE_DATA_A    = '0;
        o_WRITE_ENABLE_B  = 1'b0;
        o_READ_ENABLE_B   = 1'b0;
        o_WRITE_ADDRESS_B = '0;
        o_READ_ADDRESS_B  = '0;
        o_WRITE_DATA_B    = '0;
        if (w1_found) begin
            if (req_bus.i_REQ_WRITE[w1_idx]) begin
                o_WRITE_ENABLE_A  = 1'b1;
                o_WRITE_ADDRESS_A = req_bus.i_REQ_ADDRESS[int'(w1_idx)*p_ADDRESS_WIDTH +: p_ADDRESS_WIDTH];
                o_WRITE_DATA_A    = req_bus.i_REQ_WDATA[int'(w1_idx)*p_DATA_WIDTH +: p_DATA_WIDTH];
            end else begin
                o_READ_ENABLE_A   = 1'b1;
                o_READ_ADDRESS_A  = req_bus.i_REQ_ADDRESS[int'(w1_idx)*p_ADDRESS_WIDTH +: p_ADDRESS_WIDTH];
            end
        end
        if (w2_found) begin
            if (req_bus.i_REQ_WRITE[w2_idx]) begin
                o_WRITE_ENABLE_B  = 1'b1;
                o_WRITE_ADDRESS_B = req_bus.i_REQ_ADDRESS[int'(w2_idx)*p_ADDRESS_WIDTH +: p_ADDRESS_WIDTH];
                o_WRITE_DATA_B    = req_bus.i_REQ_WDATA[int'(w2_idx)*p_DATA_WIDTH +: p_DATA_WIDTH];
            end else begin
                o_READ_ENABLE_B   = 1'b1;
                o_READ_ADDRESS_B  = req_bus.i_REQ_ADDRESS[int'(w2_idx)*p_ADDRESS_WIDTH +: p_ADDRESS_WIDTH];
            end
        end
    end

    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            r_RR_PTR      <= '0;
            r_RSP_PENDING <= '0;
            r_RSP_PORT    <= '0;
        end else begin
            if (w1_found) r_RR_PTR <= ptr_next;
            r_RSP_PENDING <= grant & ~req_bus.i_REQ_WRITE;
            r_RSP_PORT    <= port_b_sel;
        end
    end

    // The BRAM registers its read data, so the port tag captured with the
    // grant lines up with the data arriving one cycle later.
    always_comb begin
        req_bus.o_RSP_DATA = '0;
        for (int k = 0; k < p_NUM_REQ; k++) begin
            if (r_RSP_PENDING[k]) begin
                req_bus.o_RSP_DATA[k*p_DATA_WIDTH +: p_DATA_WIDTH] = r_RSP_PORT[k] ? i_READ_DATA_B : i_READ_DATA_A;
            end
        end
    end

    assign req_bus.o_REQ_READY = grant;
    assign req_bus.o_RSP_VALID = r_RSP_PENDING;
endmodule

// File: tb/tb_dual_port_bram_arbiter.sv
// tb/tb_dual_port_bram_arbiter.sv - self-checking bench for dual_port_bram_arbiter
module tb_dual_port_bram_arbiter;
    localparam int NR = 4;
    localparam int AW = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dual_port_bram_arbiter_if #(.p_NUM_REQ(NR), .p_ADDRESS_WIDTH(AW), .p_DATA_WIDTH(DW)) bus ();

    logic          we_a, re_a, we_b, re_b;
    logic [AW-1:0] wa_a, ra_a, wa_b, ra_b;
    logic [DW-1:0] wd_a, wd_b;
    logic [DW-1:0] rd_a = '0, rd_b = '0;

    dual_port_bram_arbiter #(.p_NUM_REQ(NR), .p_ADDRESS_WIDTH(AW), .p_DATA_WIDTH(DW)) dut (
        .i_CLK             (clk),
        .i_RESET_N         (rst_n),
        .req_bus           (bus),
        .o_WRITE_ENABLE_A  (we_a),
        .o_READ_ENABLE_A   (re_a),
        .o_WRITE_ADDRESS_A (wa_a),
        .o_READ_ADDRESS_A  (ra_a),
        .o_WRITE_DATA_A    (wd_a),
        .i_READ_DATA_A     (rd_a),
        .o_WRITE_ENABLE_B  (we_b),
        .o_READ_ENABLE_B   (re_b),
        .o_WRITE_ADDRESS_B (wa_b),
        .o_READ_ADDRESS_B  (ra_b),
        .o_WRITE_DATA_B    (wd_b),
        .i_READ_DATA_B     (rd_b)
    );

    // Reference state: golden memory contents, round-robin start, expected responses
    logic [DW-1:0] gold [16];
    int            m_ptr = 0;
    bit            exp_v [NR];
    logic [DW-1:0] exp_d [NR];
    bit            ram_init = 1'b0;

    // Dual-port RAM with registered read; read-enable low returns zero
    logic [DW-1:0] ram [16];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 16; i++) ram[i] <= gold[i];
        end else begin
            if (we_a) ram[wa_a] <= wd_a;
            if (we_b) ram[wa_b] <= wd_b;
        end
        rd_a <= re_a ? ram[ra_a] : '0;
        rd_b <= re_b ? ram[ra_b] : '0;
    end

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int k, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.i_REQ_VALID[k]             = 1'b1;
        bus.i_REQ_WRITE[k]             = w;
        bus.i_REQ_ADDRESS[k*AW +: AW]  = a;
        bus.i_REQ_WDATA[k*DW +: DW]    = d;
    endtask

    task automatic idle(input int k);
        bus.i_REQ_VALID[k] = 1'b0;
    endtask

    function automatic logic [AW-1:0] addr_of(input int k);
        return bus.i_REQ_ADDRESS[k*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] data_of(input int k);
        return bus.i_REQ_WDATA[k*DW +: DW];
    endfunction

    // Same address with at least one write means the two cannot share a cycle
    function automatic bit clash(input int a, input int b);
        return (addr_of(a) == addr_of(b)) && (bus.i_REQ_WRITE[a] || bus.i_REQ_WRITE[b]);
    endfunction

    // Expected {write_en, read_en, write_addr, read_addr, write_data} for a port
    function automatic logic [63:0] exp_port(input int w);
        if (w < 0) return 64'd0;
        if (bus.i_REQ_WRITE[w]) return 64'({1'b1, 1'b0, addr_of(w), {AW{1'b0}}, data_of(w)});
        return 64'({1'b0, 1'b1, {AW{1'b0}}, addr_of(w), {DW{1'b0}}});
    endfunction

    // One clock cycle: check outputs against the reference at the falling
    // edge, then advance the reference across the rising edge.
    task automatic step(output logic [NR-1:0] rdy, output logic [3:0] en);
        int            order[$];
        int            w1, w2, last;
        logic [NR-1:0] e_rdy, e_rv;
        logic [NR*DW-1:0] e_rd;
        @(negedge clk);
        e_rv = '0;
        e_rd = '0;
        for (int k = 0; k < NR; k++) begin
            if (exp_v[k]) begin
                e_rv[k]          = 1'b1;
                e_rd[k*DW +: DW] = exp_d[k];
            end
        end
        for (int i = 0; i < NR; i++) begin
            if (bus.i_REQ_VALID[(m_ptr + i) % NR]) order.push_back((m_ptr + i) % NR);
        end
        w1 = -1;
        w2 = -1;
        if (order.size() > 0) w1 = order[0];
        for (int j = 1; j < order.size(); j++) begin
            if (!clash(w1, order[j])) begin
                w2 = order[j];
                break;
            end
        end
        e_rdy = '0;
        if (w1 >= 0) e_rdy[w1] = 1'b1;
        if (w2 >= 0) e_rdy[w2] = 1'b1;
        check_eq("ready", 64'(bus.o_REQ_READY), 64'(e_rdy));
        check_eq("rsp_valid", 64'(bus.o_RSP_VALID), 64'(e_rv));
        check_eq("rsp_data", 64'(bus.o_RSP_DATA), 64'(e_rd));
        check_eq("port_a", 64'({we_a, re_a, wa_a, ra_a, wd_a}), exp_port(w1));
        check_eq("port_b", 64'({we_b, re_b, wa_b, ra_b, wd_b}), exp_port(w2));
        rdy = bus.o_REQ_READY;
        en  = {we_a, re_a, we_b, re_b};
        @(posedge clk);
        for (int k = 0; k < NR; k++) exp_v[k] = 1'b0;
        foreach (order[i]) begin
            if ((order[i] == w1 || order[i] == w2) && !bus.i_REQ_WRITE[order[i]]) begin
                exp_v[order[i]] = 1'b1;
                exp_d[order[i]] = gold[addr_of(order[i])];
            end
        end
        foreach (order[i]) begin
            if ((order[i] == w1 || order[i] == w2) && bus.i_REQ_WRITE[order[i]])
                gold[addr_of(order[i])] = data_of(order[i]);
        end
        if (w1 >= 0) begin
            last  = (w2 >= 0) ? w2 : w1;
            m_ptr = (last + 1) % NR;
        end
        #1;
    endtask

    logic [NR-1:0] rdy;
    logic [3:0]    en;

    initial begin
        bus.i_REQ_VALID   = '0;
        bus.i_REQ_WRITE   = '0;
        bus.i_REQ_ADDRESS = '0;
        bus.i_REQ_WDATA   = '0;
        for (int i = 0; i < 16; i++) gold[i] = 8'($urandom_range(255, 0));
        for (int k = 0; k < NR; k++) set_req(k, 1'b0, 4'(k + 1), 8'h00);

        // Reset with all requesters valid: nothing may be granted or enabled
        ram_init = 1'b1;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_ready", 64'(bus.o_REQ_READY), 64'd0);
        check_eq("reset_enables", 64'({we_a, re_a, we_b, re_b}), 64'd0);
        check_eq("reset_rsp_valid", 64'(bus.o_RSP_VALID), 64'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        ram_init = 1'b0;

        // Four reads at 1..4: pairs (0,1) then (2,3)
        step(rdy, en);
        check_eq("s1_c0_ready", 64'(rdy), 64'(4'b0011));
        idle(0); idle(1);
        step(rdy, en);
        check_eq("s1_c1_ready", 64'(rdy), 64'(4'b1100));
        check_eq("s1_c1_rsp", 64'(bus.o_RSP_VALID), 64'(4'b1100));
        idle(2); idle(3);
        step(rdy, en);

        // Write 0xA5 @7 against a read @7 in the same cycle
        set_req(0, 1'b1, 4'd7, 8'hA5);
        set_req(1, 1'b0, 4'd7, 8'h00);
        step(rdy, en);
        check_eq("s2_write_only", 64'(rdy), 64'(4'b0001));
        idle(0);
        step(rdy, en);
        check_eq("s2_read_next", 64'(rdy), 64'(4'b0010));
        check_eq("s2_rsp_valid", 64'(bus.o_RSP_VALID), 64'(4'b0010));
        check_eq("s2_rsp_data", 64'(bus.o_RSP_DATA[15:8]), 64'h00A5);
        idle(1);

        // Two reads of addr 5 from requesters 2 and 3 with pointer at 2
        set_req(2, 1'b0, 4'd5, 8'h00);
        set_req(3, 1'b0, 4'd5, 8'h00);
        step(rdy, en);
        check_eq("s3_both_read", 64'(rdy), 64'(4'b1100));
        check_eq("s3_both_ports", 64'(en), 64'(4'b0101));
        idle(2); idle(3);
        step(rdy, en);

        // Two writes to addr 3: serialized, requester 1's data lands last
        set_req(0, 1'b1, 4'd3, 8'h11);
        set_req(1, 1'b1, 4'd3, 8'h22);
        step(rdy, en);
        check_eq("s4_first_write", 64'(rdy), 64'(4'b0001));
        idle(0);
        step(rdy, en);
        check_eq("s4_second_write", 64'(rdy), 64'(4'b0010));
        idle(1);
        step(rdy, en);
        check_eq("s4_ram3", 64'(ram[3]), 64'h0022);

        // Requester 3 alone: granted every cycle on port A only
        for (int c = 0; c < 8; c++) begin
            set_req(3, 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)), 8'($urandom_range(255, 0)));
            step(rdy, en);
            check_eq("s5_solo_ready", 64'(rdy), 64'(4'b1000));
            check_eq("s5_port_b_idle", 64'(en[1:0]), 64'd0);
        end
        idle(3);
        step(rdy, en);

        // All four reading: two grants every cycle, nobody waits more than one cycle
        for (int k = 0; k < NR; k++) set_req(k, 1'b0, 4'(8 + k), 8'h00);
        for (int c = 0; c < 6; c++) begin
            step(rdy, en);
            check_eq("s6_two_grants", 64'($countones(rdy)), 64'd2);
        end
        for (int k = 0; k < NR; k++) idle(k);
        step(rdy, en);

        // Reset while a read response is on the bus
        set_req(1, 1'b0, 4'd9, 8'h00);
        step(rdy, en);
        check_eq("s7_pending", 64'(bus.o_RSP_VALID), 64'(4'b0010));
        for (int k = 0; k < NR; k++) set_req(k, 1'b0, 4'(k), 8'h00);
        #1 rst_n = 1'b0;
        m_ptr = 0;
        for (int k = 0; k < NR; k++) exp_v[k] = 1'b0;
        #1;
        check_eq("s7_rsp_dropped", 64'(bus.o_RSP_VALID), 64'd0);
        check_eq("s7_ready_low", 64'(bus.o_REQ_READY), 64'd0);
        #1 rst_n = 1'b1;
        step(rdy, en);
        check_eq("s7_first_grant_0", 64'(rdy[0]), 64'd1);

        // Random traffic; ungranted requests are held stable
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < NR; k++) begin
                if (!bus.i_REQ_VALID[k] || rdy[k]) begin
                    if ($urandom_range(9, 0) < 6)
                        set_req(k, 1'($urandom_range(1, 0)),
                                ($urandom_range(1, 0) == 1) ? 4'($urandom_range(3, 0)) : 4'($urandom_range(15, 0)),
                                8'($urandom_range(255, 0)));
                    else
                        idle(k);
                end
            end
            step(rdy, en);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
